// File: rtl/vga_game_frontend.sv
// vga_game_frontend: pixel timing, registered syncs/colour, key debounce and paddle for a game core
module vga_game_frontend #(
    parameter int   CLK_DIV     = 2,
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   CW          = 10,
    parameter int   DB_CYCLES   = 16,
    parameter int   PW          = 8,
    parameter int   PADDLE_STEP = 4,
    parameter int   PADDLE_MAX  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    keys,
    input  logic [2:0]    rgb_in,
    output logic          pix_en,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          display_on,
    output logic          frame_start,
    output logic [3:0]    keys_db,
    output logic [PW-1:0] hpaddle,
    output logic          hsync,
    output logic          vsync,
    output logic [2:0]    rgb
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DB_CYCLES) + 1;
    localparam int PW1 = PW + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HD = CW'(H_DISPLAY);
    localparam logic [CW-1:0] VD = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [BW-1:0] DB_LAST = BW'(DB_CYCLES - 1);
    localparam logic [PW:0] STEP = PW1'(PADDLE_STEP);
    localparam logic [PW:0] PMAX = PW1'(PADDLE_MAX);

    logic [DW-1:0] div, div_next;
    logic [3:0]    sync1, sync2;
    logic [BW-1:0] db_cnt [4];
    logic          h_act, v_act;
    logic [PW:0]   pad_dec, pad_inc, pad_next;

    // Divider step, visible-area and sync-window decode, saturating paddle step
    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
        display_on = (hpos < HD) && (vpos < VD);
        h_act = (hpos >= HS_START) && (hpos <= HS_END);
        v_act = (vpos >= VS_START) && (vpos <= VS_END);
        pad_dec = {1'b0, hpaddle} - STEP;
        pad_inc = {1'b0, hpaddle} + STEP;
        pad_next = (keys_db[0] & ~keys_db[1]) ? (pad_dec[PW] ? '0 : pad_dec) :
                   (keys_db[1] & ~keys_db[0]) ? ((pad_inc > PMAX) ? PMAX : pad_inc) :
                   {1'b0, hpaddle};
    end

    // Pixel enable, raster counters and the frame-wrap pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            pix_en <= 1'b0;
            hpos <= '0;
            vpos <= '0;
            frame_start <= 1'b0;
        end else begin
            div <= div_next;
            pix_en <= (div_next == DIV_LAST);
            frame_start <= pix_en && (hpos == H_LAST) && (vpos == V_LAST);
            if (pix_en) begin
                hpos <= (hpos == H_LAST) ? '0 : hpos + 1'b1;
                if (hpos == H_LAST)
                    vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
            end
        end
    end

    // Syncs and blanked colour registered together so they stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            rgb <= '0;
        end else if (pix_en) begin
            hsync <= h_act ? SYNC_POL : ~SYNC_POL;
            vsync <= v_act ? SYNC_POL : ~SYNC_POL;
            rgb <= display_on ? rgb_in : 3'b000;
        end
    end

    // Key synchroniser and per-key stability counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            keys_db <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == keys_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    keys_db[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Paddle moves once per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hpaddle <= PW'(PADDLE_MAX / 2);
        else if (frame_start)
            hpaddle <= pad_next[PW-1:0];
    end
endmodule

// File: tb/tb_vga_game_frontend.sv
// tb_vga_game_frontend: randomized checks of timing, syncs, colour, debounce, paddle and reset
module tb_vga_game_frontend;
    localparam int CD = 2;
    localparam int HD = 8, HF = 2, HS = 3, HB = 2, HT = HD + HF + HS + HB;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1, VT = VD + VF + VS + VB;
    localparam int FR = CD * HT * VT;
    localparam int DB = 16;
    localparam int CW = 10, PW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] keys = 4'b0;
    logic [2:0] seed = 3'b0;
    logic [2:0] rgb_in;
    logic pix_en, display_on, frame_start, hsync, vsync;
    logic [CW-1:0] hpos, vpos;
    logic [3:0] keys_db;
    logic [PW-1:0] hpaddle;
    logic [2:0] rgb;
    int n;
    int checks = 0, errors = 0;

    vga_game_frontend #(
        .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .CW(CW), .DB_CYCLES(DB), .PW(PW), .PADDLE_STEP(4), .PADDLE_MAX(255)
    ) dut (
        .clk(clk), .reset(reset), .keys(keys), .rgb_in(rgb_in), .pix_en(pix_en),
        .hpos(hpos), .vpos(vpos), .display_on(display_on), .frame_start(frame_start),
        .keys_db(keys_db), .hpaddle(hpaddle), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Toy game core: colour is a seeded function of the current pixel
    assign rgb_in = 3'(int'(hpos) + 3 * int'(vpos)) ^ seed;

    // Clock edges since the last reset release
    always @(posedge clk or posedge reset)
        if (reset) n <= 0;
        else n <= n + 1;

    task automatic do_reset(input logic [3:0] k);
        keys = k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        seed = 3'b101;
        keys = 4'hf;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 9;
        if (pix_en !== 1'b0) begin errors++; $display("FAIL reset pix_en got %b exp 0", pix_en); end
        if (hpos !== '0) begin errors++; $display("FAIL reset hpos got %0d exp 0", hpos); end
        if (vpos !== '0) begin errors++; $display("FAIL reset vpos got %0d exp 0", vpos); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset frame_start got %b exp 0", frame_start); end
        if (keys_db !== 4'h0) begin errors++; $display("FAIL reset keys_db got %h exp 0", keys_db); end
        if (hpaddle !== 8'd127) begin errors++; $display("FAIL reset hpaddle got %0d exp 127", hpaddle); end
        if (hsync !== 1'b1) begin errors++; $display("FAIL reset hsync got %b exp 1", hsync); end
        if (vsync !== 1'b1) begin errors++; $display("FAIL reset vsync got %b exp 1", vsync); end
        if (rgb !== 3'b0) begin errors++; $display("FAIL reset rgb got %0d exp 0", rgb); end
    endtask

    task automatic test_timing();
        seed = 3'($urandom);
        do_reset(4'h0);
        repeat (2 * FR + 37) begin
            int p, h, v, qh, qv;
            logic e_pe, e_fs, e_hs, e_vs, e_do;
            logic [2:0] e_rgb;
            @(negedge clk);
            p = n / CD;
            h = p % HT;
            v = (p / HT) % VT;
            qh = (p - 1) % HT;
            qv = ((p - 1) / HT) % VT;
            e_pe = (n % CD) == CD - 1;
            e_fs = n > 0 && (n % CD) == 0 && (p % (HT * VT)) == 0;
            e_do = h < HD && v < VD;
            e_hs = !(p > 0 && qh >= HD + HF && qh < HD + HF + HS);
            e_vs = !(p > 0 && qv >= VD + VF && qv < VD + VF + VS);
            e_rgb = (p > 0 && qh < HD && qv < VD) ? (3'(qh + 3 * qv) ^ seed) : 3'b0;
            checks += 8;
            if (pix_en !== e_pe) begin errors++; $display("FAIL pix_en n=%0d got %b exp %b", n, pix_en, e_pe); end
            if (hpos !== CW'(h)) begin errors++; $display("FAIL hpos n=%0d got %0d exp %0d", n, hpos, h); end
            if (vpos !== CW'(v)) begin errors++; $display("FAIL vpos n=%0d got %0d exp %0d", n, vpos, v); end
            if (display_on !== e_do) begin errors++; $display("FAIL display_on n=%0d got %b exp %b", n, display_on, e_do); end
            if (frame_start !== e_fs) begin errors++; $display("FAIL frame_start n=%0d got %b exp %b", n, frame_start, e_fs); end
            if (hsync !== e_hs) begin errors++; $display("FAIL hsync n=%0d got %b exp %b", n, hsync, e_hs); end
            if (vsync !== e_vs) begin errors++; $display("FAIL vsync n=%0d got %b exp %b", n, vsync, e_vs); end
            if (rgb !== e_rgb) begin errors++; $display("FAIL rgb n=%0d got %0d exp %0d", n, rgb, e_rgb); end
        end
    endtask

    task automatic test_debounce();
        do_reset(4'h0);
        for (int g = 0; g < 5; g++) begin
            int k, len;
            k = (g == 0) ? 0 : $urandom_range(0, 3);
            len = (g == 0) ? 5 : $urandom_range(1, DB - 1);
            keys[k] = 1'b1;
            repeat (len) @(negedge clk);
            keys[k] = 1'b0;
            repeat (30) begin
                @(negedge clk);
                checks++;
                if (keys_db !== 4'h0) begin errors++; $display("FAIL glitch key=%0d len=%0d got %h exp 0", k, len, keys_db); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            keys[k] = 1'b1;
            for (int i = 1; i <= DB + 4; i++) begin
                @(negedge clk);
                checks++;
                if (keys_db[k] !== (i >= DB + 2)) begin errors++; $display("FAIL press key=%0d clk=%0d got %b exp %b", k, i, keys_db[k], i >= DB + 2); end
            end
            keys[k] = 1'b0;
            for (int i = 1; i <= DB + 4; i++) begin
                @(negedge clk);
                checks++;
                if (keys_db[k] !== (i < DB + 2)) begin errors++; $display("FAIL release key=%0d clk=%0d got %b exp %b", k, i, keys_db[k], i < DB + 2); end
            end
        end
    endtask

    task automatic test_paddle(input logic [1:0] k, input int frames);
        do_reset({2'b00, k});
        repeat (frames * FR + 5) begin
            int f, e;
            @(negedge clk);
            f = (n >= 1) ? (n - 1) / FR : 0;
            e = (k == 2'b01) ? ((127 - 4 * f < 0) ? 0 : 127 - 4 * f) :
                (k == 2'b10) ? ((127 + 4 * f > 255) ? 255 : 127 + 4 * f) : 127;
            checks++;
            if (hpaddle !== PW'(e)) begin errors++; $display("FAIL paddle keys=%b n=%0d got %0d exp %0d", k, n, hpaddle, e); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'b0010);
        repeat ($urandom_range(FR + 10, 3 * FR)) @(negedge clk);
        checks++;
        if (hpaddle === 8'd127) begin errors++; $display("FAIL premove paddle got %0d exp not 127", hpaddle); end
        #2 reset = 1'b1;
        #1;
        checks += 9;
        if (pix_en !== 1'b0) begin errors++; $display("FAIL async pix_en got %b exp 0", pix_en); end
        if (hpos !== '0) begin errors++; $display("FAIL async hpos got %0d exp 0", hpos); end
        if (vpos !== '0) begin errors++; $display("FAIL async vpos got %0d exp 0", vpos); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL async frame_start got %b exp 0", frame_start); end
        if (keys_db !== 4'h0) begin errors++; $display("FAIL async keys_db got %h exp 0", keys_db); end
        if (hpaddle !== 8'd127) begin errors++; $display("FAIL async hpaddle got %0d exp 127", hpaddle); end
        if (hsync !== 1'b1) begin errors++; $display("FAIL async hsync got %b exp 1", hsync); end
        if (vsync !== 1'b1) begin errors++; $display("FAIL async vsync got %b exp 1", vsync); end
        if (rgb !== 3'b0) begin errors++; $display("FAIL async rgb got %0d exp 0", rgb); end
        keys = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (FR + 20) begin
            int p;
            @(negedge clk);
            p = n / CD;
            checks += 3;
            if (pix_en !== ((n % CD) == CD - 1)) begin errors++; $display("FAIL restart pix_en n=%0d got %b", n, pix_en); end
            if (hpos !== CW'(p % HT)) begin errors++; $display("FAIL restart hpos n=%0d got %0d exp %0d", n, hpos, p % HT); end
            if (vpos !== CW'((p / HT) % VT)) begin errors++; $display("FAIL restart vpos n=%0d got %0d exp %0d", n, vpos, (p / HT) % VT); end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_debounce();
        test_paddle(2'b01, 34);
        test_paddle(2'b10, 36);
        test_paddle(2'b11, 4);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_game_frontend.md
Name: vga_game_frontend

Overview:
Parametrised front-end that sits between the board pins and an 8bitworkshop-style game core. It generates the pixel clock enable and the VGA timing counters and syncs from configurable parameters. It debounces raw board keys and turns left/right keys into a saturating paddle position that updates once per frame. It registers the core's colour output with the syncs and blanks it outside the visible area, so the core needs no divided clock and no hard-wired paddle input.

Parameters:
CLK_DIV, 2, clk cycles per pixel (>=1)
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active low)
CW, 10, width of hpos/vpos
DB_CYCLES, 16, clk cycles a key must be stable before it is accepted
PW, 8, paddle position width
PADDLE_STEP, 4, paddle change per frame
PADDLE_MAX, 255, upper paddle limit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
keys  in  4  raw board keys, active-high, asynchronous; [0] left, [1] right, [3:2] debounce only
rgb_in  in  3  core colour for current hpos/vpos (combinational from the core)
pix_en  out  1  one-clk pixel enable
hpos  out  CW  current pixel column
vpos  out  CW  current line
display_on  out  1  hpos<H_DISPLAY && vpos<V_DISPLAY
frame_start  out  1  one-clk pulse at the start of each frame
keys_db  out  4  debounced keys
hpaddle  out  PW  paddle position
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
rgb  out  3  registered, blanked colour

Behaviour:
- Reset is asynchronous and active-high, clock is clk. All state returns to reset values immediately, including on assertion mid-frame.
- Reset values:
  - div counter=0, pix_en=0, hpos=0, vpos=0, frame_start=0, keys_db=0.
  - Synchronisers and debounce counters=0.
  - hpaddle=PADDLE_MAX/2 (integer division).
  - hsync=vsync=~SYNC_POL (inactive level), rgb=0.
- Divider:
  - Counter runs 0..CLK_DIV-1. pix_en=1 for the single clk where the counter equals CLK_DIV-1.
  - CLK_DIV=1: pix_en is high every clk after reset release.
- Counters advance only when pix_en=1.
  - H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined the same way.
  - hpos wraps from H_TOTAL-1 to 0. vpos increments on that wrap and wraps from V_TOTAL-1 to 0.
- display_on is combinational from hpos/vpos.
- Sync windows:
  - hsync active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vsync active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- Output registers load on pix_en:
  - hsync/vsync take the sync decode of the current hpos/vpos.
  - rgb takes display_on ? rgb_in : 0.
  - Latency is exactly one pixel period; syncs and rgb stay mutually aligned.
- frame_start is a one-clk pulse on the clk where hpos/vpos transition (V_TOTAL-1, H_TOTAL-1) -> (0,0). It does not pulse on reset release.
- Debounce, per key:
  - Two-flop synchroniser feeds a counter.
  - The counter clears when the synchronised value equals keys_db; otherwise it increments.
  - At DB_CYCLES-1, keys_db takes the new value and the counter clears.
  - Any glitch shorter than DB_CYCLES clks is ignored.
- Paddle updates only on frame_start:
  - keys_db[0]&~keys_db[1]: hpaddle=max(hpaddle-PADDLE_STEP, 0).
  - keys_db[1]&~keys_db[0]: hpaddle=min(hpaddle+PADDLE_STEP, PADDLE_MAX).
  - Both or neither: hold.
  - Arithmetic is done at PW+1 bits so there is no wrap-around.

Test Plan:
- Defaults, release reset -> pix_en every 2nd clk; hpos 0..799; vpos=1 after 800 pix_en; vpos wraps 524->0.
- hpos 656..751 -> hsync output low for 96 pixels (192 clk), starting one pixel after hpos=656. vpos 490..491 -> vsync low for 1600 pixels.
- rgb_in=3'b111 held -> rgb=7 only for registered pixels hpos<640 && vpos<480, else 0. frame_start period=840000 clk.
- keys[0] pulse of 5 clk -> keys_db unchanged. Held 30 clk -> keys_db[0]=1 no earlier than 2+16 clk after the edge.
- keys_db[0] held -> hpaddle 127,123,...,3,0 (0 at 32nd frame_start, then stays 0). keys_db[1] held -> climbs to 255 and saturates. Both held -> hpaddle constant.
- Reset asserted at hpos=300, vpos=100 -> hsync/vsync=1, rgb=0, hpaddle=127, counters 0 asynchronously. After release, counting restarts from 0,0.
